// File: rtl/video_ddr_read_ctrl_pkg.sv
// Shared definitions for the DDR frame-read DMA: FSM states, AXI encodings
// and a constant-evaluable log2 helper used for widths.
package video_ddr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_REQ   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/video_ddr_read_ctrl_if.sv
// AXI read address / read data channels between the frame-read DMA (master)
// and the DDR interconnect (slave).
interface video_ddr_read_ctrl_if #(
  parameter int DW  = 512,
  parameter int AW  = 32,
  parameter int IDW = 4
);
  // Both channels use strict AXI valid/ready: a transfer happens on a rising
  // clock edge where valid and ready are both high; once valid is raised the
  // payload is held stable and valid stays high until that transfer occurs.
  logic [IDW-1:0] arid;
  logic [AW-1:0]  araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic           arvalid;
  logic           arready;

  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/video_ddr_read_ctrl.sv
// Frame-read DMA: fetches a frame from DDR as AXI INCR bursts and pushes every
// beat into the display FIFO, pacing requests by FIFO space and outstanding ARs.
module video_ddr_read_ctrl
  import video_ddr_pkg::*;
#(
  parameter int g_DDR_AXI_DWIDTH    = 512,
  parameter int g_DDR_AXI_AWIDTH    = 32,
  parameter int g_AXI_IDWIDTH       = 4,
  parameter int g_VIDEO_FIFO_AWIDTH = 12,
  parameter int g_BURST_LEN         = 16,
  parameter int g_MAX_OUTSTANDING   = 4
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           frame_start_i,
  input  logic [g_DDR_AXI_AWIDTH-1:0]    frame_base_i,
  input  logic [23:0]                    total_beats_i,
  input  logic [g_VIDEO_FIFO_AWIDTH-1:0] fifo_wcount_i,
  video_ddr_read_ctrl_if.master          axi,
  output logic                           fifo_wen_o,
  output logic [g_DDR_AXI_DWIDTH-1:0]    fifo_wdata_o,
  output logic                           busy_o,
  output logic                           frame_done_o,
  output logic                           rresp_err_o,
  output state_e                         state_o
);

  localparam int AAW        = g_DDR_AXI_AWIDTH;
  localparam int FAW        = g_VIDEO_FIFO_AWIDTH;
  localparam int BYTE_SHIFT = clog2(g_DDR_AXI_DWIDTH / 8);
  localparam int OUT_W      = clog2(g_MAX_OUTSTANDING + 1);
  localparam int RES_W      = FAW + 1;
  localparam int CMP_W      = FAW + 2;
  localparam logic [CMP_W-1:0] SPACE_LIMIT = CMP_W'((1 << FAW) - 4);
  localparam logic [8:0]       BURST       = 9'(g_BURST_LEN);

  state_e                        state_q;
  logic [AAW-1:0]                araddr_q;
  logic [7:0]                    arlen_q;
  logic                          arvalid_q;
  logic [23:0]                   rem_ar_q;
  logic [23:0]                   rem_r_q;
  logic [RES_W-1:0]              reserved_q;
  logic [OUT_W-1:0]              outstanding_q;
  logic                          busy_q;
  logic                          done_q;
  logic                          err_q;
  logic                          fifo_wen_q;
  logic [g_DDR_AXI_DWIDTH-1:0]   fifo_wdata_q;

  logic [8:0]       next_len;
  logic             ar_hs;
  logic             r_beat;
  logic             space_ok;
  logic             slot_ok;
  logic [RES_W-1:0] reserved_d;
  logic [OUT_W-1:0] outstanding_d;

  always_comb begin
    next_len      = (rem_ar_q >= 24'(g_BURST_LEN)) ? BURST : rem_ar_q[8:0];
    ar_hs         = arvalid_q & axi.arready;
    r_beat        = axi.rvalid & busy_q;
    // Reserved space counts beats already requested but not yet written.
    space_ok      = (CMP_W'(fifo_wcount_i) + CMP_W'(reserved_q) + CMP_W'(next_len))
                    <= SPACE_LIMIT;
    slot_ok       = outstanding_q < OUT_W'(g_MAX_OUTSTANDING);
    reserved_d    = reserved_q + (ar_hs ? RES_W'(next_len) : '0)
                               - (r_beat ? RES_W'(1) : '0);
    outstanding_d = outstanding_q + (ar_hs ? OUT_W'(1) : '0)
                                  - ((r_beat && axi.rlast) ? OUT_W'(1) : '0);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= ST_IDLE;
      araddr_q      <= '0;
      arlen_q       <= '0;
      arvalid_q     <= 1'b0;
      rem_ar_q      <= '0;
      rem_r_q       <= '0;
      reserved_q    <= '0;
      outstanding_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      fifo_wen_q    <= 1'b0;
      fifo_wdata_q  <= '0;
    end else begin
      fifo_wen_q    <= r_beat;
      if (r_beat) fifo_wdata_q <= axi.rdata;
      reserved_q    <= reserved_d;
      outstanding_q <= outstanding_d;
      if (r_beat) rem_r_q <= rem_r_q - 24'd1;
      if (r_beat && (axi.rresp != AXI_RESP_OKAY)) err_q <= 1'b1;
      done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (frame_start_i) begin
            araddr_q <= frame_base_i;
            rem_ar_q <= total_beats_i;
            rem_r_q  <= total_beats_i;
            err_q    <= 1'b0;
            if (total_beats_i == 24'd0) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (space_ok && slot_ok) begin
            arlen_q   <= 8'(next_len - 9'd1);
            arvalid_q <= 1'b1;
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          // next_len cannot change here: rem_ar_q only moves on this handshake.
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            araddr_q  <= araddr_q + (AAW'(next_len) << BYTE_SHIFT);
            rem_ar_q  <= rem_ar_q - 24'(next_len);
            state_q   <= (rem_ar_q == 24'(next_len)) ? ST_DRAIN : ST_CHECK;
          end
        end
        ST_DRAIN: begin
          if (rem_r_q == 24'd0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign axi.arid     = '0;
  assign axi.araddr   = araddr_q;
  assign axi.arlen    = arlen_q;
  assign axi.arsize   = 3'(BYTE_SHIFT);
  assign axi.arburst  = AXI_BURST_INCR;
  assign axi.arvalid  = arvalid_q;
  assign axi.rready   = busy_q;
  assign fifo_wen_o   = fifo_wen_q;
  assign fifo_wdata_o = fifo_wdata_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign rresp_err_o  = err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_video_ddr_read_ctrl.sv
// Bench for video_ddr_read_ctrl: a small AXI read responder, a FIFO-side
// scoreboard and table-driven frames plus hand-written corner sequences.
module tb_video_ddr_read_ctrl;
  import video_ddr_pkg::*;

  localparam int DW  = 512;
  localparam int AW  = 32;
  localparam int IDW = 4;
  localparam int FAW = 12;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic           frame_start = 1'b0;
  logic [AW-1:0]  frame_base  = '0;
  logic [23:0]    total_beats = '0;
  logic [FAW-1:0] fifo_wcount = '0;
  logic           fifo_wen;
  logic [DW-1:0]  fifo_wdata;
  logic           busy;
  logic           frame_done;
  logic           rresp_err;
  state_e         state;

  video_ddr_read_ctrl_if #(.DW(DW), .AW(AW), .IDW(IDW)) axi ();

  video_ddr_read_ctrl #(
    .g_DDR_AXI_DWIDTH(DW), .g_DDR_AXI_AWIDTH(AW), .g_AXI_IDWIDTH(IDW),
    .g_VIDEO_FIFO_AWIDTH(FAW), .g_BURST_LEN(16), .g_MAX_OUTSTANDING(4)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .frame_start_i(frame_start),
    .frame_base_i(frame_base), .total_beats_i(total_beats),
    .fifo_wcount_i(fifo_wcount), .axi(axi),
    .fifo_wen_o(fifo_wen), .fifo_wdata_o(fifo_wdata), .busy_o(busy),
    .frame_done_o(frame_done), .rresp_err_o(rresp_err), .state_o(state)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } ar_t;

  ar_t         pend_q[$];
  ar_t         ar_log[$];
  logic [DW-1:0] exp_q[$];
  int beat_idx   = 0;
  int frame_beat = 0;
  int err_beat   = -1;
  bit arready_en = 1'b1;
  bit r_en       = 1'b1;
  int rlast_cnt  = 0;
  int wen_cnt    = 0;
  int done_cnt   = 0;
  int arv_seen   = 0;

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a);
    return {16{a}};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- AXI read responder ----------------
  always @(posedge clk) begin
    if (!rstn) begin
      pend_q.delete();
      beat_idx = 0;
    end else begin
      if (axi.arvalid && axi.arready) begin
        pend_q.push_back('{addr: axi.araddr, len: axi.arlen});
        ar_log.push_back('{addr: axi.araddr, len: axi.arlen});
      end
      if (axi.rvalid && axi.rready) begin
        frame_beat++;
        if (axi.rlast) begin
          rlast_cnt++;
          void'(pend_q.pop_front());
          beat_idx = 0;
        end else begin
          beat_idx++;
        end
      end
    end
  end

  always @(negedge clk) begin
    axi.arready = arready_en;
    if (rstn && r_en && (pend_q.size() > 0)) begin
      axi.rvalid = 1'b1;
      axi.rdata  = beat_data(pend_q[0].addr + AW'(beat_idx) * 32'd64);
      axi.rlast  = (beat_idx == int'(pend_q[0].len));
      axi.rresp  = (frame_beat == err_beat) ? 2'b10 : 2'b00;
    end else begin
      axi.rvalid = 1'b0;
      axi.rdata  = '0;
      axi.rlast  = 1'b0;
      axi.rresp  = 2'b00;
    end
  end

  // ---------------- FIFO-side scoreboard ----------------
  always @(negedge clk) begin
    if (rstn) begin
      if (fifo_wen) begin
        wen_cnt++;
        if (exp_q.size() == 0) chk("unexpected_fifo_write", 1, 0);
        else chk_data("fifo_data", fifo_wdata, exp_q.pop_front());
      end
      if (frame_done) done_cnt++;
      if (axi.arvalid) arv_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame(input logic [AW-1:0] base, input int total);
    ar_log.delete();
    wen_cnt = 0; done_cnt = 0; rlast_cnt = 0; frame_beat = 0; arv_seen = 0;
    for (int i = 0; i < total; i++) exp_q.push_back(beat_data(base + AW'(i) * 32'd64));
    frame_base  = base;
    total_beats = 24'(total);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    repeat (2) tick();
  endtask

  task automatic check_frame(input string tag, input logic [AW-1:0] base,
                             input int total, input int exp_ars);
    chk({tag, "_ar_count"}, ar_log.size(), exp_ars);
    for (int k = 0; k < ar_log.size() && k < exp_ars; k++) begin
      int blen = total - 16 * k;
      if (blen > 16) blen = 16;
      chk($sformatf("%s_araddr%0d", tag, k), int'(ar_log[k].addr), int'(base + AW'(k) * 32'h400));
      chk($sformatf("%s_arlen%0d", tag, k), int'(ar_log[k].len), blen - 1);
    end
    chk({tag, "_wen_count"}, wen_cnt, total);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_exp_left"}, exp_q.size(), 0);
    chk({tag, "_busy_after"}, int'(busy), 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [AW-1:0] base;
    int            total;
    int            exp_ars;
  } vec_t;
  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [AW-1:0] a0;
    logic [7:0]    l0;
    int unstable;

    vecs[0] = '{32'h1000_0000, 40, 3};
    vecs[1] = '{32'h2000_0000, 16, 1};
    vecs[2] = '{32'h0000_0400, 1, 1};
    vecs[3] = '{32'h3000_0800, 33, 3};
    vecs[4] = '{32'h4000_0000, 100, 7};

    // Reset state
    repeat (3) tick();
    chk("rst_arvalid", int'(axi.arvalid), 0);
    chk("rst_araddr", int'(axi.araddr), 0);
    chk("rst_rready", int'(axi.rready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fifo_wen", int'(fifo_wen), 0);
    chk("rst_state", int'(state), int'(ST_IDLE));
    rstn = 1'b1;
    repeat (2) tick();
    chk("rst_arsize", int'(axi.arsize), 6);
    chk("rst_arburst", int'(axi.arburst), 1);

    // Table-driven frames, free-flowing bus
    for (int v = 0; v < 5; v++) begin
      start_frame(vecs[v].base, vecs[v].total);
      wait_done(1000);
      check_frame($sformatf("vec%0d", v), vecs[v].base, vecs[v].total, vecs[v].exp_ars);
    end

    // AR held stable while arready is low
    arready_en = 1'b0;
    start_frame(32'h5000_0000, 40);
    n = 0;
    while (!axi.arvalid && n < 10) begin tick(); n++; end
    chk("hold_arvalid_up", int'(axi.arvalid), 1);
    a0 = axi.araddr;
    l0 = axi.arlen;
    unstable = 0;
    repeat (10) begin
      tick();
      if (axi.arvalid !== 1'b1 || axi.araddr !== a0 || axi.arlen !== l0) unstable++;
    end
    chk("hold_unstable_cycles", unstable, 0);
    chk("hold_araddr", int'(a0), 32'h5000_0000);
    chk("hold_arlen", int'(l0), 15);
    arready_en = 1'b1;
    wait_done(1000);
    check_frame("hold", 32'h5000_0000, 40, 3);

    // FIFO space gating at the margin
    fifo_wcount = 12'd4080;
    start_frame(32'h6000_0000, 16);
    repeat (20) tick();
    chk("space_no_ar", ar_log.size(), 0);
    chk("space_arvalid_low", int'(axi.arvalid), 0);
    fifo_wcount = 12'd4076;
    n = 0;
    while (!axi.arvalid && n < 3) begin tick(); n++; end
    chk("space_ar_issued", int'(axi.arvalid), 1);
    chk("space_ar_latency_ok", int'(n <= 2), 1);
    fifo_wcount = '0;
    wait_done(1000);
    check_frame("space", 32'h6000_0000, 16, 1);

    // Outstanding limit with R stalled; start while busy is ignored
    r_en = 1'b0;
    start_frame(32'h7000_0000, 128);
    repeat (30) tick();
    chk("outst_ar_count", ar_log.size(), 4);
    chk("outst_arvalid_low", int'(axi.arvalid), 0);
    frame_base  = 32'h7100_0000;
    total_beats = 24'd5;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("busy_start_ignored", int'(busy), 1);
    r_en = 1'b1;
    n = 0;
    while (ar_log.size() < 5 && n < 60) begin tick(); n++; end
    chk("outst_fifth_ar", ar_log.size(), 5);
    chk("outst_rlast_before_fifth", rlast_cnt, 1);
    wait_done(1000);
    check_frame("outst", 32'h7000_0000, 128, 8);

    // Error response is sticky until the next accepted start
    err_beat = 7;
    start_frame(32'h0800_0000, 40);
    wait_done(1000);
    check_frame("err", 32'h0800_0000, 40, 3);
    chk("err_set", int'(rresp_err), 1);
    repeat (5) tick();
    chk("err_sticky", int'(rresp_err), 1);
    err_beat = -1;
    start_frame(32'h0900_0000, 16);
    chk("err_cleared_on_start", int'(rresp_err), 0);
    wait_done(1000);
    check_frame("err2", 32'h0900_0000, 16, 1);
    chk("err_stays_clear", int'(rresp_err), 0);

    // Zero-length frame
    start_frame(32'h0A00_0000, 0);
    n = 0;
    while (done_cnt == 0 && n < 2) begin tick(); n++; end
    chk("zero_done", done_cnt, 1);
    chk("zero_no_ar", ar_log.size(), 0);
    chk("zero_no_arvalid", arv_seen, 0);

    // Asynchronous reset mid-burst, then a clean frame
    start_frame(32'h0B00_0000, 64);
    repeat (12) tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_arvalid", int'(axi.arvalid), 0);
    chk("arst_araddr", int'(axi.araddr), 0);
    chk("arst_rready", int'(axi.rready), 0);
    chk("arst_fifo_wen", int'(fifo_wen), 0);
    chk_data("arst_fifo_wdata", fifo_wdata, '0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_state", int'(state), int'(ST_IDLE));
    exp_q.delete();
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    start_frame(32'h0C00_0000, 40);
    wait_done(1000);
    check_frame("post_rst", 32'h0C00_0000, 40, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
